game_sequencer: RTL
===================

# game_sequencer

Top-level game flow controller for the runner game. It sequences a round through idle, countdown, run, hit, level-up and end screens, and owns the collision checker's reset. It also generates the level-dependent scroll strobe that advances the obstacle field, and tracks lives and level. It sits between the player input and VGA frame timing on one side and the collision checker and block generator on the other.

## Interface
- COUNT_FRAMES, 60: frame ticks per countdown step (3 steps).
- HOLD_FRAMES, 120: frame ticks spent in HIT and LEVEL_UP.
- SCROLL_DIV, 4: frames per scroll step at level 0; must be > NUM_LEVELS-1.
- LIVES, 3: lives at game start, 1..3.
- NUM_LEVELS, 4: levels per game, 1..4.
- clk  in  1  system clock (25 MHz pixel clock domain).
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  player start button, already synchronized and debounced, level.
- frame_tick  in  1  one-clk pulse per VGA frame.
- win  in  1  sticky goal indication from collision checker.
- game_over  in  1  sticky hit indication from collision checker.
- collision_rst  out  1  synchronous reset to collision checker and block generator.
- scroll_en  out  1  one-clk strobe: advance obstacle field one step.
- level  out  2  current level, 0-based.
- lives  out  2  remaining lives.
- countdown  out  2  digit to display: 3,2,1 in COUNTDOWN, else 0.
- state  out  3  current state code, for display muxing.

## Operation
- start_rise = start high this cycle and low the previous cycle (one internal register). Only start_rise is ever acted on.
- States:
  - IDLE (0): on start_rise, go to COUNTDOWN and set lives=LIVES, level=0.
  - COUNTDOWN (1): countdown loads 3 and decrements every COUNT_FRAMES ticks. On expiry at 1, go to RUN.
  - RUN (2): win has priority if both inputs are high. win goes to LEVEL_UP. game_over goes to HIT, and lives decrements on the transition.
  - HIT (3): after HOLD_FRAMES ticks, go to COUNTDOWN if lives>0, else LOSE.
  - LEVEL_UP (4): after HOLD_FRAMES ticks, go to VICTORY if level==NUM_LEVELS-1. Otherwise increment level and go to COUNTDOWN.
  - LOSE (5) / VICTORY (6): on start_rise, go to IDLE.
  - Unused code 7 goes to IDLE.
- Frame timer: a single counter, cleared on every state entry, increments on frame_tick. "N ticks elapsed" means the Nth frame_tick since entry.
- collision_rst = 0 only while state==RUN. It is registered from next-state, so it falls in the same cycle state becomes RUN and rises in the same cycle state leaves RUN.
- Scroll:
  - Period P = SCROLL_DIV - level.
  - In RUN, a scroll counter counts frame_ticks. On the tick that takes it to P it pulses scroll_en for that cycle and resets to 0.
  - The counter is cleared outside RUN. scroll_en is never high outside RUN.
- Arithmetic: lives never underflows; decrement happens only from RUN with lives≥1. level saturates at NUM_LEVELS-1.
- start_rise is ignored in every state except IDLE, LOSE and VICTORY.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, collision_rst=1, scroll_en=0, level=0, lives=LIVES, countdown=0, start history=0.
- State transitions take effect on the clk edge after the qualifying input.
- From a start_rise in IDLE, state is COUNTDOWN on the next edge.
- RUN is entered 3·COUNT_FRAMES ticks after COUNTDOWN entry.
- win/game_over are sampled every cycle in RUN. They read 0 at RUN entry because collision_rst was held high for ≥1 frame.
- Asserting rst mid-round forces the reset values immediately. This includes collision_rst=1, regardless of current state.

## Structure
- Shared package game_pkg: state encoding constants (IDLE..VICTORY) and the 3-bit state width. The display and HUD modules use these for muxing.
- One sub-module, frame_timer. It has a clear input and a frame_tick input, and a compare against a terminal-count input that gives a done pulse. It is instanced twice: once as the state timer and once as the scroll counter.

## Test plan
All scenarios use COUNT_FRAMES=2, HOLD_FRAMES=3, SCROLL_DIV=4, LIVES=2, NUM_LEVELS=2.
- Reset then start pulse: state goes 0→1. countdown reads 3,2,1 with 2 frame_ticks each. State is 2 on the 6th tick, with collision_rst falling in the same cycle.
- In RUN at level 0, 12 frame_ticks produce exactly 3 scroll_en pulses, on ticks 4, 8 and 12. Each pulse is one clk wide.
- In RUN, raise game_over: state goes to 3 and lives goes to 1. After 3 ticks, state is 1. A second game_over leads to lives 0, then HIT, then LOSE (5). start_rise then returns to IDLE.
- In RUN, raise win and game_over in the same cycle: state goes to LEVEL_UP (4) and lives is unchanged. After 3 ticks, level is 1 and state is COUNTDOWN. In the next RUN, scroll_en comes every 3 ticks. A win then leads to VICTORY (6).
- Hold start high through COUNTDOWN and RUN: no extra transitions occur. Releasing and re-pressing start in RUN has no effect.
- Assert rst asynchronously mid-RUN, between clk edges: all outputs take their reset values before the next edge.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_pkg : shared state encoding for the runner game flow     Rev 1.0
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUN       = 3'd2,
        ST_HIT       = 3'd3,
        ST_LEVEL_UP  = 3'd4,
        ST_LOSE      = 3'd5,
        ST_VICTORY   = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/game_sequencer_frame_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_timer : frame_tick counter with clear and terminal-count done   Rev 1.0
// ---------------------------------------------------------------------------
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         frame_tick,
    input  logic [W-1:0] terminal,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_inc;

    assign count_inc = count_q + 1'b1;
    // done marks the tick that reaches terminal; the counter wraps on that tick
    assign done      = frame_tick && (count_inc == terminal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (frame_tick) begin
            count_q <= done ? '0 : count_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_sequencer : round flow, lives/level tracking and scroll strobe   Rev 1.0
// ---------------------------------------------------------------------------
module game_sequencer
    import game_pkg::*;
#(
    parameter int COUNT_FRAMES = 60,
    parameter int HOLD_FRAMES  = 120,
    parameter int SCROLL_DIV   = 4,
    parameter int LIVES        = 3,
    parameter int NUM_LEVELS   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               win,
    input  logic               game_over,
    output logic               collision_rst,
    output logic               scroll_en,
    output logic [1:0]         level,
    output logic [1:0]         lives,
    output logic [1:0]         countdown,
    output logic [STATE_W-1:0] state
);

    localparam int C_MAX_CF = (COUNT_FRAMES > HOLD_FRAMES) ? COUNT_FRAMES : HOLD_FRAMES;
    localparam int C_MAX_T  = (C_MAX_CF > SCROLL_DIV) ? C_MAX_CF : SCROLL_DIV;
    localparam int TW       = $clog2(C_MAX_T + 1);
    localparam logic [1:0] C_LAST_LEVEL = 2'(NUM_LEVELS - 1);

    state_e     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [1:0] level_q, level_d;
    logic [1:0] countdown_q, countdown_d;
    logic       start_q;
    logic       collision_rst_q;
    logic       scroll_en_q;

    logic          start_rise;
    logic          t_clear, t_done;
    logic [TW-1:0] t_term;
    logic          s_clear, s_done;
    logic [TW-1:0] s_term;

    assign start_rise = start && !start_q;

    // State timer restarts on every state change
    assign t_clear = (state_d != state_q);
    assign t_term  = (state_q == ST_COUNTDOWN) ? TW'(COUNT_FRAMES) : TW'(HOLD_FRAMES);

    assign s_clear = (state_q != ST_RUN);
    assign s_term  = TW'(SCROLL_DIV) - TW'(level_q);

    frame_timer #(.W(TW)) u_state_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (t_clear),
        .frame_tick (frame_tick),
        .terminal   (t_term),
        .done       (t_done)
    );

    frame_timer #(.W(TW)) u_scroll_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (s_clear),
        .frame_tick (frame_tick),
        .terminal   (s_term),
        .done       (s_done)
    );

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        level_d     = level_q;
        countdown_d = countdown_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_COUNTDOWN;
                    lives_d = 2'(LIVES);
                    level_d = '0;
                end
            end
            ST_COUNTDOWN: begin
                if (t_done) begin
                    if (countdown_q <= 2'd1) state_d = ST_RUN;
                    else                     countdown_d = countdown_q - 2'd1;
                end
            end
            ST_RUN: begin
                if (win) begin
                    state_d = ST_LEVEL_UP;
                end else if (game_over) begin
                    state_d = ST_HIT;
                    if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                end
            end
            ST_HIT: begin
                if (t_done) state_d = (lives_q != 2'd0) ? ST_COUNTDOWN : ST_LOSE;
            end
            ST_LEVEL_UP: begin
                if (t_done) begin
                    if (level_q >= C_LAST_LEVEL) begin
                        state_d = ST_VICTORY;
                    end else begin
                        level_d = level_q + 2'd1;
                        state_d = ST_COUNTDOWN;
                    end
                end
            end
            ST_LOSE, ST_VICTORY: begin
                if (start_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Digit reloads on every countdown entry and blanks elsewhere
        if (state_d == ST_COUNTDOWN && state_q != ST_COUNTDOWN) countdown_d = 2'd3;
        else if (state_d != ST_COUNTDOWN)                       countdown_d = 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            lives_q         <= 2'(LIVES);
            level_q         <= '0;
            countdown_q     <= '0;
            start_q         <= 1'b0;
            collision_rst_q <= 1'b1;
            scroll_en_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            lives_q         <= lives_d;
            level_q         <= level_d;
            countdown_q     <= countdown_d;
            start_q         <= start;
            collision_rst_q <= (state_d != ST_RUN);
            scroll_en_q     <= s_done && (state_q == ST_RUN) && (state_d == ST_RUN);
        end
    end

    assign collision_rst = collision_rst_q;
    assign scroll_en     = scroll_en_q;
    assign level         = level_q;
    assign lives         = lives_q;
    assign countdown     = countdown_q;
    assign state         = state_q;

endmodule
`default_nettype wire
